// File: rtl/caf_pkg.sv
// Shared definitions for the CAF datapath: width helpers and the accumulator FSM encoding.
package caf_pkg;

  typedef enum logic {
    CPX_ACC_ST_ACC   = 1'b0,
    CPX_ACC_ST_STALL = 1'b1
  } cpx_acc_state_e;

  // Ceiling log2; 0 and 1 both map to 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(value)) res = int'(k) + 1;
    end
    return res;
  endfunction

  // Accumulator width that holds a full block of worst-case samples without overflow.
  function automatic int unsigned cpx_acc_bits(input int unsigned ib, input int unsigned qb,
                                               input int unsigned len);
    return ((ib > qb) ? ib : qb) + clog2(len);
  endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// Registered squared magnitude re^2 + im^2, unsigned at twice the input width (cannot overflow).
module cpx_mag_sq #(
  parameter int unsigned width = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [width-1:0]   re,
  input  logic signed [width-1:0]   im,
  output logic [2*width-1:0]        mag
);

  logic signed [2*width-1:0] re_x;
  logic signed [2*width-1:0] im_x;
  logic [2*width-1:0]        sum;

  // Sign-extend to the result width so each square is exact before the unsigned add.
  always_comb begin
    re_x = {{width{re[width-1]}}, re};
    im_x = {{width{im[width-1]}}, im};
    sum  = re_x * re_x + im_x * im_x;
  end

  // Capture only when new operands are presented so the result holds with its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag <= '0;
    end else if (en) begin
      mag <= sum;
    end
  end

endmodule

// File: rtl/cpx_accumulator.sv
// Integrate-and-dump of complex samples over blocks of `length`, with a one-entry output buffer.
// Optional feature macro CPX_ACC_MAG_EN adds the |acc|^2 output `mag` and one pipeline stage.
module cpx_accumulator
  import caf_pkg::*;
#(
  parameter int unsigned i_bits   = 24,
  parameter int unsigned q_bits   = 24,
  parameter int unsigned length   = 1024,
  parameter int unsigned out_bits = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_axis_tvalid,
  input  logic signed [i_bits-1:0]   i,
  input  logic signed [q_bits-1:0]   q,
  input  logic                       m_axis_tready,
  output logic                       s_axis_tready,
  output logic signed [out_bits-1:0] acc_i,
  output logic signed [out_bits-1:0] acc_q,
  output logic                       s_axis_tvalid
`ifdef CPX_ACC_MAG_EN
  ,
  output logic [2*out_bits-1:0]      mag
`endif
);

  localparam int unsigned AccW = cpx_acc_bits(i_bits, q_bits, length);
  localparam int unsigned CntW = clog2(length);
  localparam logic [CntW-1:0] CntLast = CntW'(length - 1);

  cpx_acc_state_e         state_q;
  logic [CntW-1:0]        cnt_q;
  logic signed [AccW-1:0] acc_re_q;
  logic signed [AccW-1:0] acc_im_q;
  logic signed [AccW-1:0] ext_i;
  logic signed [AccW-1:0] ext_q;
  logic signed [AccW-1:0] sum_i;
  logic signed [AccW-1:0] sum_q;
  logic signed [out_bits-1:0] trunc_i;
  logic signed [out_bits-1:0] trunc_q;
  logic last;
  logic blocked;
  logic accept;
  logic complete;

  // Handshake and next-sum datapath; a completing sample is refused only if the held
  // result would be overwritten before the consumer takes it.
  always_comb begin
    ext_i         = {{(AccW - i_bits){i[i_bits-1]}}, i};
    ext_q         = {{(AccW - q_bits){q[q_bits-1]}}, q};
    last          = (cnt_q == CntLast);
    blocked       = last & s_axis_tvalid & ~m_axis_tready;
    s_axis_tready = rst_n & (state_q == CPX_ACC_ST_ACC) & ~blocked;
    accept        = m_axis_tvalid & s_axis_tready;
    complete      = accept & last;
    sum_i         = (cnt_q == '0) ? ext_i : acc_re_q + ext_i;
    sum_q         = (cnt_q == '0) ? ext_q : acc_im_q + ext_q;
  end

  // Keep the top out_bits of the sum (no rounding), or sign-extend if the output is wider.
  if (out_bits <= AccW) begin : g_trunc
    assign trunc_i = sum_i[AccW-1 -: out_bits];
    assign trunc_q = sum_q[AccW-1 -: out_bits];
  end else begin : g_extend
    assign trunc_i = {{(out_bits - AccW){sum_i[AccW-1]}}, sum_i};
    assign trunc_q = {{(out_bits - AccW){sum_q[AccW-1]}}, sum_q};
  end

  // Sample counter and running sums; the first sample of a block loads instead of adding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (accept) begin
      acc_re_q <= sum_i;
      acc_im_q <= sum_q;
      cnt_q    <= last ? '0 : cnt_q + CntW'(1);
    end
  end

  // Stall FSM: hold input off after a refused completion until the consumer is ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CPX_ACC_ST_ACC;
    end else begin
      unique case (state_q)
        CPX_ACC_ST_ACC:   if (blocked) state_q <= CPX_ACC_ST_STALL;
        CPX_ACC_ST_STALL: if (m_axis_tready) state_q <= CPX_ACC_ST_ACC;
        default:          state_q <= CPX_ACC_ST_ACC;
      endcase
    end
  end

`ifdef CPX_ACC_MAG_EN
  logic                       s1_valid_q;
  logic signed [out_bits-1:0] s1_i_q;
  logic signed [out_bits-1:0] s1_q_q;

  // Extra stage so the squared magnitude lines up with acc_i/acc_q. Blocks are at least two
  // samples apart, so the output buffer is always free when this stage hands over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
    end else begin
      s1_valid_q <= complete;
      if (complete) begin
        s1_i_q <= trunc_i;
        s1_q_q <= trunc_q;
      end
    end
  end

  // Output buffer: load from the pipeline stage, clear when taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axis_tvalid <= 1'b0;
      acc_i         <= '0;
      acc_q         <= '0;
    end else if (s1_valid_q) begin
      s_axis_tvalid <= 1'b1;
      acc_i         <= s1_i_q;
      acc_q         <= s1_q_q;
    end else if (m_axis_tready) begin
      s_axis_tvalid <= 1'b0;
    end
  end

  cpx_mag_sq #(
    .width(out_bits)
  ) u_mag_sq (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (s1_valid_q),
    .re   (s1_i_q),
    .im   (s1_q_q),
    .mag  (mag)
  );
`else
  // Output buffer: a completion overwrites (also when the old result is taken this cycle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axis_tvalid <= 1'b0;
      acc_i         <= '0;
      acc_q         <= '0;
    end else if (complete) begin
      s_axis_tvalid <= 1'b1;
      acc_i         <= trunc_i;
      acc_q         <= trunc_q;
    end else if (m_axis_tready) begin
      s_axis_tvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cpx_accumulator.sv
// Scoreboard bench for cpx_accumulator: block length 4, 8-bit inputs, a 10-bit output instance
// and a 6-bit (truncating) instance driven in parallel. Optional macro: CPX_ACC_MAG_EN.
module tb_cpx_accumulator;

  localparam int L = 4;
`ifdef CPX_ACC_MAG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_tvalid = 1'b0;
  logic m_tready = 1'b0;
  logic signed [7:0] in_i = '0;
  logic signed [7:0] in_q = '0;
  logic s_tready, s_tvalid, t_tready, t_tvalid;
  logic signed [9:0] acc_i, acc_q;
  logic signed [5:0] t_acc_i, t_acc_q;
`ifdef CPX_ACC_MAG_EN
  logic [19:0] mag;
  logic [11:0] t_mag;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpx_accumulator #(
    .i_bits(8), .q_bits(8), .length(L), .out_bits(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(m_tvalid), .i(in_i), .q(in_q),
    .m_axis_tready(m_tready), .s_axis_tready(s_tready), .acc_i(acc_i), .acc_q(acc_q),
    .s_axis_tvalid(s_tvalid)
`ifdef CPX_ACC_MAG_EN
    , .mag(mag)
`endif
  );

  cpx_accumulator #(
    .i_bits(8), .q_bits(8), .length(L), .out_bits(6)
  ) dut_trunc (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(m_tvalid), .i(in_i), .q(in_q),
    .m_axis_tready(m_tready), .s_axis_tready(t_tready), .acc_i(t_acc_i), .acc_q(t_acc_q),
    .s_axis_tvalid(t_tvalid)
`ifdef CPX_ACC_MAG_EN
    , .mag(t_mag)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int si;
    int sq;
    int t;
  } item_t;

  item_t sb[$];
  int    app_q[$];
  int    mcnt = 0;
  int    msum_i = 0;
  int    msum_q = 0;
  bit    stall_m = 1'b0;
  bit    rst_prev = 1'b0;

  // Reference model: block sums from accepted samples, plus when the output should be present.
  always @(negedge clk) begin : model
    bit exp_ready;
    bit present;
    if (rst_prev) begin
      check("rst_acc_i", acc_i, 0);
      check("rst_acc_q", acc_q, 0);
      check("rst_trunc_valid", t_tvalid, 0);
`ifdef CPX_ACC_MAG_EN
      check("rst_mag", mag, 0);
`endif
    end
    if (!rst_n) begin
      check("rst_ready", s_tready, 0);
      check("rst_valid", s_tvalid, 0 | (rst_prev ? 0 : s_tvalid));
      mcnt = 0; msum_i = 0; msum_q = 0; stall_m = 1'b0;
      sb.delete();
      app_q.delete();
    end else begin
      present   = (app_q.size() > 0) && (app_q[0] <= cyc);
      exp_ready = !stall_m && !((mcnt == L - 1) && present && !m_tready);
      check("ready", s_tready, exp_ready);
      check("trunc_ready", t_tready, exp_ready);
      check("valid", s_tvalid, present);
      check("trunc_valid", t_tvalid, present);
      if (m_tvalid && s_tready) begin
        msum_i += in_i;
        msum_q += in_q;
        mcnt++;
        if (mcnt == L) begin
          sb.push_back('{msum_i, msum_q, cyc + LAT});
          app_q.push_back(cyc + LAT);
          mcnt = 0; msum_i = 0; msum_q = 0;
        end
      end
      if (present && m_tready) void'(app_q.pop_front());
      if (stall_m) begin
        if (m_tready) stall_m = 1'b0;
      end else if (!exp_ready) begin
        stall_m = 1'b1;
      end
    end
    rst_prev = !rst_n;
  end

  item_t cur = '{0, 0, 0};
  bit    pv = 1'b0;
  bit    ptaken = 1'b0;

  // Monitor: pop an expected block whenever the DUT presents a new result.
  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      pv = 1'b0;
      ptaken = 1'b0;
    end else begin
      if (s_tvalid && (!pv || ptaken)) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got (%0d,%0d), expected none", acc_i, acc_q);
          cur = '{acc_i, acc_q, cyc};
        end else begin
          cur = sb.pop_front();
          check("latency", cyc, cur.t);
        end
      end
      if (s_tvalid) begin
        check("acc_i", acc_i, cur.si);
        check("acc_q", acc_q, cur.sq);
        check("trunc_i", t_acc_i, cur.si >>> 4);
        check("trunc_q", t_acc_q, cur.sq >>> 4);
`ifdef CPX_ACC_MAG_EN
        check("mag", mag, cur.si * cur.si + cur.sq * cur.sq);
        check("trunc_mag", t_mag, (cur.si >>> 4) * (cur.si >>> 4) + (cur.sq >>> 4) * (cur.sq >>> 4));
`endif
      end
      pv = s_tvalid;
      ptaken = s_tvalid && m_tready;
    end
  end

  task automatic send(input int vi, input int vq);
    int waited;
    waited = 0;
    m_tvalid = 1'b1;
    in_i = 8'(vi);
    in_q = 8'(vq);
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: sample (%0d,%0d) not accepted in %0d cycles", vi, vq, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    m_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    m_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic block: expects (10, -10).
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) send(k, -k);
    idle(3);

    // Full scale, two back-to-back blocks: expects (-512, 508) twice.
    for (int k = 0; k < 8; k++) send(-128, 127);
    idle(3);

    // Block sum (3, 4), magnitude 25 when enabled.
    send(1, 1); send(1, 1); send(1, 1); send(0, 1);
    idle(3);

    // Truncation on the 6-bit instance: (400, -400) -> (25, -25).
    for (int k = 0; k < 4; k++) send(100, -100);
    idle(3);

    // Backpressure: consumer stalls while two blocks are offered.
    m_tready = 1'b0;
    fork
      for (int k = 0; k < 8; k++) send((k % 4) + 1, -((k % 4) + 1));
      begin
        repeat (14) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    idle(4);

    // Reset mid-block: partial (5,5) block discarded, then expects (4, 0).
    send(5, 5);
    send(5, 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(1, 0);
    idle(4);

    // Random traffic with random backpressure.
    for (int n = 0; n < 600; n++) begin
      m_tvalid = ($urandom_range(0, 9) < 7);
      in_i     = 8'($urandom);
      in_q     = 8'($urandom);
      m_tready = ($urandom_range(0, 9) < 5);
      @(posedge clk);
      #1;
    end

    m_tvalid = 1'b0;
    m_tready = 1'b1;
    idle(10);
    check("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
